// File: rtl/serv_mtimer_pkg.sv
// serv_mtimer_pkg: register map, reset constants and byte-lane merge for the machine timer
package serv_mtimer_pkg;
  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] PRESCALE    = 3'd4;
  localparam logic [63:0] MTIMECMP_RST = '1;
  function automatic logic [31:0] wb_merge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] sel);
    for (int i = 0; i < 4; i++) wb_merge[8*i+:8] = sel[i] ? dat[8*i+:8] : old[8*i+:8];
  endfunction
endpackage

// File: rtl/serv_mtimer_prescaler.sv
// serv_mtimer_prescaler: free-running counter that wraps at the reload value and emits a 1-cycle tick
module serv_mtimer_prescaler
  import serv_mtimer_pkg::*;
#(
  parameter int W       = 16,
  parameter bit RST_ALL = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [W-1:0]         i_dat,
  input  logic [(W+7)/8-1:0]   i_sel,
  output logic [W-1:0]         o_prescale,
  output logic                 o_tick
);
  logic [W-1:0] cnt;
  assign o_tick = cnt == o_prescale;
  always_ff @(posedge i_clk)
    if (i_rst && RST_ALL) begin
      cnt        <= '0;
      o_prescale <= '0;
    end else begin
      cnt <= (i_we || o_tick) ? '0 : cnt + 1'b1;
      for (int i = 0; i < W; i++) if (i_we && i_sel[i/8]) o_prescale[i] <= i_dat[i];
    end
endmodule

// File: rtl/serv_mtimer.sv
// serv_mtimer: RISC-V mtime/mtimecmp Wishbone peripheral driving the level timer interrupt
module serv_mtimer
  import serv_mtimer_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int PRESCALE_W     = 16,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_mtip
);
  localparam bit W64     = WIDTH == 64;
  localparam bit RST_ALL = RESET_STRATEGY != "NONE";
  localparam logic [63:0] MASK = W64 ? '1 : 64'h0000_0000_FFFF_FFFF;
  logic [63:0] mtime, mtimecmp;
  logic [31:0] shadow, rdt;
  logic [PRESCALE_W-1:0] prescale;
  logic tick, access;
  logic [7:0] hit;
  assign access = i_wb_cyc & !o_wb_ack & !i_rst;
  assign hit = {8{access & i_wb_we}} & (8'd1 << i_wb_adr);
  serv_mtimer_prescaler #(.W(PRESCALE_W), .RST_ALL(RST_ALL)) prescaler (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (hit[PRESCALE]),
    .i_dat      (i_wb_dat[PRESCALE_W-1:0]),
    .i_sel      (i_wb_sel[(PRESCALE_W+7)/8-1:0]),
    .o_prescale (prescale),
    .o_tick     (tick)
  );
  always_comb
    rdt = i_wb_adr == MTIME_LO    ? mtime[31:0] :
          i_wb_adr == MTIME_HI    ? shadow :
          i_wb_adr == MTIMECMP_LO ? mtimecmp[31:0] :
          i_wb_adr == MTIMECMP_HI ? mtimecmp[63:32] :
          i_wb_adr == PRESCALE    ? 32'(prescale) : '0;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_mtip   <= 1'b0;
    end else begin
      o_wb_ack <= i_wb_cyc & !o_wb_ack;
      o_mtip   <= mtime >= mtimecmp;
    end
  // a bus write to either mtime half suppresses that cycle's increment entirely
  always_ff @(posedge i_clk)
    if (i_rst && RST_ALL) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST & MASK;
      shadow   <= '0;
      o_wb_rdt <= '0;
    end else begin
      if (hit[MTIME_LO]) mtime[31:0] <= wb_merge(mtime[31:0], i_wb_dat, i_wb_sel);
      else if (hit[MTIME_HI] && W64) mtime[63:32] <= wb_merge(mtime[63:32], i_wb_dat, i_wb_sel);
      else if (tick) mtime <= (mtime + 64'd1) & MASK;
      if (hit[MTIMECMP_LO]) mtimecmp[31:0] <= wb_merge(mtimecmp[31:0], i_wb_dat, i_wb_sel);
      if (hit[MTIMECMP_HI] && W64) mtimecmp[63:32] <= wb_merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);
      if (access) o_wb_rdt <= rdt;
      if (access && !i_wb_we && i_wb_adr == MTIME_LO) shadow <= mtime[63:32] & MASK[63:32];
    end
endmodule
